// File: rtl/aes_out_serializer.sv
// aes_out_serializer: buffers 128-bit AES result blocks in a small FIFO and
// hands them to the host as a stream of 32-bit words under valid/ready.
// Free-space reporting lets upstream launch a block only when it can land.
module aes_out_serializer #(
  parameter int DEPTH     = 4,
  parameter bit MSW_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_enable,
  input  logic                     i_blk_valid,
  input  logic [127:0]             i_blk_data,
  input  logic                     i_clear,
  input  logic                     i_word_ready,
  output logic                     o_word_valid,
  output logic [31:0]              o_word,
  output logic                     o_last,
  output logic [$clog2(DEPTH):0]   o_free_cnt,
  output logic                     o_empty,
  output logic                     o_full,
  output logic                     o_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [DEPTH-1:0][127:0] mem;
  logic [PW-1:0]           wr_ptr, rd_ptr, used;
  logic [1:0]              widx;
  logic                    overflow;
  logic                    push, xfer, pop, full, empty, accept;
  logic [3:0][31:0]        head_words;
  logic [1:0]              wsel;

  // Pointers carry one extra wrap bit, so the difference is the fill level.
  assign used   = wr_ptr - rd_ptr;
  assign full   = (used == DEPTH_P);
  assign empty  = (used == '0);

  // The core holds its valid while disabled; only enabled cycles are fresh blocks.
  assign push   = i_blk_valid && i_enable;
  assign xfer   = !empty && i_word_ready;
  assign pop    = xfer && (widx == 2'd3);
  // A final-word pop on the same edge frees the slot the new block lands in.
  assign accept = push && (!full || pop);

  // Block storage; contents survive i_clear, only pointers are flushed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    mem <= '0;
    else if (accept && !i_clear)  mem[wr_ptr[AW-1:0]] <= i_blk_data;
  end

  // Pointer, word-index and sticky overflow state; clear beats push and pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      widx     <= '0;
      overflow <= 1'b0;
    end else if (i_clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      widx     <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept)          wr_ptr   <= wr_ptr + PW'(1);
      if (pop)             rd_ptr   <= rd_ptr + PW'(1);
      if (xfer)            widx     <= widx + 2'd1;
      if (push && !accept) overflow <= 1'b1;
    end
  end

  // Word select straight off the registered head entry: stable under stalls.
  assign head_words   = mem[rd_ptr[AW-1:0]];
  assign wsel         = MSW_FIRST ? ~widx : widx;
  assign o_word       = head_words[wsel];

  assign o_word_valid = !empty;
  assign o_last       = !empty && (widx == 2'd3);
  assign o_free_cnt   = DEPTH_P - used;
  assign o_empty      = empty;
  assign o_full       = full;
  assign o_overflow   = overflow;
endmodule

// File: tb/tb_aes_out_serializer.sv
// Directed bench: two instances (MSW-first and LSW-first) share all inputs.
module tb_aes_out_serializer;
  localparam int DEPTH = 4;
  localparam logic [127:0] XBLK = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0, reset = 1'b1;
  logic         i_enable = 1'b1, i_blk_valid = 1'b0, i_clear = 1'b0, i_word_ready = 1'b0;
  logic [127:0] i_blk_data = '0;

  logic        m_valid, m_last, m_empty, m_full, m_ovf;
  logic [31:0] m_word;
  logic [2:0]  m_free;
  logic        l_valid, l_last, l_empty, l_full, l_ovf;
  logic [31:0] l_word;
  logic [2:0]  l_free;

  int errors = 0, checks = 0;

  aes_out_serializer #(.DEPTH(DEPTH), .MSW_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .i_enable(i_enable), .i_blk_valid(i_blk_valid),
    .i_blk_data(i_blk_data), .i_clear(i_clear), .i_word_ready(i_word_ready),
    .o_word_valid(m_valid), .o_word(m_word), .o_last(m_last), .o_free_cnt(m_free),
    .o_empty(m_empty), .o_full(m_full), .o_overflow(m_ovf));

  aes_out_serializer #(.DEPTH(DEPTH), .MSW_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .i_enable(i_enable), .i_blk_valid(i_blk_valid),
    .i_blk_data(i_blk_data), .i_clear(i_clear), .i_word_ready(i_word_ready),
    .o_word_valid(l_valid), .o_word(l_word), .o_last(l_last), .o_free_cnt(l_free),
    .o_empty(l_empty), .o_full(l_full), .o_overflow(l_ovf));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Tagged block: MSW-order word j of block t is {t, j}.
  function automatic logic [127:0] blk(input logic [7:0] t);
    return {t, 24'd0, t, 24'd1, t, 24'd2, t, 24'd3};
  endfunction
  function automatic logic [31:0] wd(input logic [7:0] t, input int j);
    return {t, 24'(j)};
  endfunction

  task automatic do_clear;
    i_clear = 1'b1; tick; i_clear = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk); #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", m_valid); end
    checks++; if (m_word !== 32'h0) begin errors++; $display("FAIL rst_word got %h want 0", m_word); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL rst_last got %b want 0", m_last); end
    checks++; if (m_free !== 3'd4) begin errors++; $display("FAIL rst_free got %0d want 4", m_free); end
    checks++; if (m_empty !== 1'b1 || m_full !== 1'b0 || m_ovf !== 1'b0) begin
      errors++; $display("FAIL rst_flags got e%b f%b o%b want e1 f0 o0", m_empty, m_full, m_ovf); end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_single;
    logic [31:0] exp_w [4];
    exp_w = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};
    i_word_ready = 1'b1;
    i_blk_valid = 1'b1; i_blk_data = XBLK; tick; i_blk_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (m_valid !== 1'b1 || m_word !== exp_w[k]) begin
        errors++; $display("FAIL single_word%0d got v%b %h want v1 %h", k, m_valid, m_word, exp_w[k]); end
      checks++; if (m_last !== (k == 3)) begin
        errors++; $display("FAIL single_last%0d got %b want %b", k, m_last, k == 3); end
      tick;
    end
    checks++; if (m_empty !== 1'b1) begin errors++; $display("FAIL single_empty got %b want 1", m_empty); end
    i_word_ready = 1'b0;
  endtask

  task automatic test_lsw_stall;
    logic [31:0] exp_w [4];
    logic [23:0] pat;
    int n;
    exp_w = '{32'h70b4c55a, 32'hd8cdb780, 32'h6a7b0430, 32'h69c4e0d8};
    pat = 24'b1001_0110_0011_0100_1010_0010;
    n = 0;
    i_word_ready = 1'b0;
    i_blk_valid = 1'b1; i_blk_data = XBLK; tick; i_blk_valid = 1'b0;
    for (int c = 0; c < 24 && n < 4; c++) begin
      i_word_ready = pat[c];
      checks++; if (l_valid !== 1'b1 || l_word !== exp_w[n]) begin
        errors++; $display("FAIL lsw_word c%0d got v%b %h want v1 %h", c, l_valid, l_word, exp_w[n]); end
      checks++; if (l_last !== (n == 3)) begin
        errors++; $display("FAIL lsw_last c%0d got %b want %b", c, l_last, n == 3); end
      if (pat[c]) n++;
      tick;
    end
    checks++; if (n != 4) begin errors++; $display("FAIL lsw_xfers got %0d want 4", n); end
    i_word_ready = 1'b1; tick; tick;
    checks++; if (l_empty !== 1'b1 || l_valid !== 1'b0) begin
      errors++; $display("FAIL lsw_drained got e%b v%b want e1 v0", l_empty, l_valid); end
    i_word_ready = 1'b0;
  endtask

  task automatic test_fill_overflow;
    i_word_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      i_blk_valid = 1'b1; i_blk_data = blk(8'hA0 + 8'(b)); tick;
    end
    i_blk_valid = 1'b0;
    checks++; if (m_full !== 1'b1 || m_free !== 3'd0 || m_ovf !== 1'b0) begin
      errors++; $display("FAIL fill_full got f%b c%0d o%b want f1 c0 o0", m_full, m_free, m_ovf); end
    i_blk_valid = 1'b1; i_blk_data = blk(8'hEE); tick; i_blk_valid = 1'b0;
    checks++; if (m_ovf !== 1'b1 || m_free !== 3'd0) begin
      errors++; $display("FAIL fill_ovf got o%b c%0d want o1 c0", m_ovf, m_free); end
    i_word_ready = 1'b1;
    for (int b = 0; b < 4; b++)
      for (int j = 0; j < 4; j++) begin
        checks++; if (m_valid !== 1'b1 || m_word !== wd(8'hA0 + 8'(b), j)) begin
          errors++; $display("FAIL fill_order b%0d w%0d got %h want %h", b, j, m_word, wd(8'hA0 + 8'(b), j)); end
        tick;
      end
    checks++; if (m_empty !== 1'b1 || m_ovf !== 1'b1) begin
      errors++; $display("FAIL fill_end got e%b o%b want e1 o1", m_empty, m_ovf); end
    i_word_ready = 1'b0;
    do_clear;
    checks++; if (m_ovf !== 1'b0) begin errors++; $display("FAIL clear_ovf got %b want 0", m_ovf); end
  endtask

  task automatic test_full_boundary;
    logic [7:0] ord [4];
    ord = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
    i_word_ready = 1'b0;
    i_blk_valid = 1'b1; i_blk_data = blk(8'hB0); tick;
    for (int b = 0; b < 3; b++) begin i_blk_data = blk(ord[b]); tick; end
    i_blk_valid = 1'b0;
    i_word_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      checks++; if (m_word !== wd(8'hB0, j)) begin
        errors++; $display("FAIL bnd_a w%0d got %h want %h", j, m_word, wd(8'hB0, j)); end
      tick;
    end
    checks++; if (m_last !== 1'b1 || m_full !== 1'b1) begin
      errors++; $display("FAIL bnd_pre got l%b f%b want l1 f1", m_last, m_full); end
    i_blk_valid = 1'b1; i_blk_data = blk(8'hB4); tick; i_blk_valid = 1'b0;
    checks++; if (m_full !== 1'b1 || m_free !== 3'd0 || m_ovf !== 1'b0) begin
      errors++; $display("FAIL bnd_post got f%b c%0d o%b want f1 c0 o0", m_full, m_free, m_ovf); end
    for (int b = 0; b < 4; b++)
      for (int j = 0; j < 4; j++) begin
        checks++; if (m_valid !== 1'b1 || m_word !== wd(ord[b], j)) begin
          errors++; $display("FAIL bnd_order b%0d w%0d got %h want %h", b, j, m_word, wd(ord[b], j)); end
        tick;
      end
    checks++; if (m_empty !== 1'b1) begin errors++; $display("FAIL bnd_empty got %b want 1", m_empty); end
    i_word_ready = 1'b0;
  endtask

  task automatic test_enable;
    i_word_ready = 1'b0;
    i_blk_valid = 1'b1;
    i_enable = 1'b1; i_blk_data = blk(8'hC1); tick;
    i_enable = 1'b0; i_blk_data = blk(8'hC2); tick;
    i_enable = 1'b1; i_blk_data = blk(8'hC3); tick;
    i_blk_valid = 1'b0;
    checks++; if (m_free !== 3'd2) begin errors++; $display("FAIL en_free got %0d want 2", m_free); end
    i_word_ready = 1'b1;
    checks++; if (m_word !== wd(8'hC1, 0)) begin errors++; $display("FAIL en_first got %h want %h", m_word, wd(8'hC1, 0)); end
    repeat (4) tick;
    checks++; if (m_word !== wd(8'hC3, 0)) begin errors++; $display("FAIL en_second got %h want %h", m_word, wd(8'hC3, 0)); end
    repeat (4) tick;
    checks++; if (m_empty !== 1'b1) begin errors++; $display("FAIL en_empty got %b want 1", m_empty); end
    i_word_ready = 1'b0;
  endtask

  task automatic test_clear_mid;
    i_word_ready = 1'b0;
    i_blk_valid = 1'b1; i_blk_data = blk(8'hD0); tick;
    i_blk_data = blk(8'hD1); tick; i_blk_valid = 1'b0;
    i_word_ready = 1'b1; tick; tick;
    checks++; if (m_word !== wd(8'hD0, 2)) begin errors++; $display("FAIL clr_pre got %h want %h", m_word, wd(8'hD0, 2)); end
    i_clear = 1'b1; i_blk_valid = 1'b1; i_blk_data = blk(8'hD2); tick;
    i_clear = 1'b0; i_blk_valid = 1'b0; i_word_ready = 1'b0;
    checks++; if (m_empty !== 1'b1 || m_valid !== 1'b0 || m_free !== 3'd4 || m_ovf !== 1'b0) begin
      errors++; $display("FAIL clr_state got e%b v%b c%0d o%b want e1 v0 c4 o0", m_empty, m_valid, m_free, m_ovf); end
    i_blk_valid = 1'b1; i_blk_data = blk(8'hD3); tick; i_blk_valid = 1'b0;
    checks++; if (m_word !== wd(8'hD3, 0) || m_last !== 1'b0 || m_free !== 3'd3) begin
      errors++; $display("FAIL clr_next got %h l%b c%0d want %h l0 c3", m_word, m_last, m_free, wd(8'hD3, 0)); end
    do_clear;
  endtask

  task automatic test_reset_mid;
    i_word_ready = 1'b0;
    i_blk_valid = 1'b1; i_blk_data = blk(8'hE0); tick;
    i_blk_data = blk(8'hE1); tick; i_blk_valid = 1'b0;
    i_word_ready = 1'b1; tick; tick;
    #2 reset = 1'b1; #1;
    checks++; if (m_valid !== 1'b0 || m_word !== 32'h0 || m_last !== 1'b0) begin
      errors++; $display("FAIL arst_out got v%b %h l%b want v0 0 l0", m_valid, m_word, m_last); end
    checks++; if (m_empty !== 1'b1 || m_free !== 3'd4 || m_full !== 1'b0 || m_ovf !== 1'b0) begin
      errors++; $display("FAIL arst_flags got e%b c%0d f%b o%b want e1 c4 f0 o0", m_empty, m_free, m_full, m_ovf); end
    i_word_ready = 1'b0;
    #1 reset = 1'b0;
    tick;
    i_blk_valid = 1'b1; i_blk_data = blk(8'hE2); tick; i_blk_valid = 1'b0;
    checks++; if (m_word !== wd(8'hE2, 0) || m_free !== 3'd3) begin
      errors++; $display("FAIL arst_next got %h c%0d want %h c3", m_word, m_free, wd(8'hE2, 0)); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_lsw_stall;
    test_fill_overflow;
    test_full_boundary;
    test_enable;
    test_clear_mid;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/aes_out_serializer.md
# aes_out_serializer

Output-side buffer that sits directly downstream of the AES core. It captures each 128-bit result block on the core's one-cycle output-valid pulse and holds it in a DEPTH-entry FIFO. It returns blocks to the host as a stream of 32-bit words under valid/ready handshaking, and reports free space so upstream logic only launches a block when its result has a slot to land in.

## Interface
- DEPTH, 4, number of 128-bit entries; power of two, ≥2
- MSW_FIRST, 1, 1: emit bits [127:96] first; 0: emit bits [31:0] first
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- i_enable  in  1  core enable; qualifies capture
- i_blk_valid  in  1  core output-valid
- i_blk_data  in  128  core output data
- i_clear  in  1  synchronous flush
- i_word_ready  in  1  host ready
- o_word_valid  out  1  word available
- o_word  out  32  current word
- o_last  out  1  current word is the 4th word of its block
- o_free_cnt  out  $clog2(DEPTH)+1  free entries
- o_empty  out  1  no stored blocks
- o_full  out  1  all entries used
- o_overflow  out  1  sticky; a block was dropped

## Operation
- Push condition: i_blk_valid && i_enable. The core holds its valid output while disabled, so capture without i_enable would duplicate blocks.
- Storage: DEPTH×128 register array, reset to 0. wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits, with the extra bit used for full/empty. Pointers wrap modulo 2·DEPTH.
- Serializer: a 2-bit word index widx selects a word from the head entry.
  - MSW_FIRST=1: o_word = head[127-32·widx -: 32].
  - MSW_FIRST=0: o_word = head[32·widx +: 32].
- Output flags:
  - o_word_valid = !o_empty.
  - o_last = o_word_valid && widx==3.
  - o_word comes from the registered array and head pointer only. It is stable while valid && !ready.
- Transfer: o_word_valid && i_word_ready.
  - widx increments on each transfer.
  - On a transfer with widx==3: pop the head (rd_ptr+1) and set widx to 0.
- Count: o_free_cnt = DEPTH − (wr_ptr − rd_ptr). o_full = (o_free_cnt==0). o_empty = (o_free_cnt==DEPTH).
- Simultaneous push and final-word pop while full: both take effect. The block is accepted, o_full stays 1, and there is no overflow.
- Push while full without a final-word pop that cycle: the block is dropped, o_overflow is set, and pointers are unchanged.
- Push while empty: the word appears the following cycle. There is no bypass in the same cycle.
- i_clear:
  - Takes priority over push and pop.
  - Resets pointers, widx and o_overflow.
  - Any push or transfer in the same cycle is discarded.
  - Array contents are not cleared.
- o_overflow is cleared only by reset or i_clear.
- Reset mid-block: the partially sent block is lost. After reset, outputs are at their reset values.

## Timing
- Reset values: o_word_valid=0, o_word=0, o_last=0, o_free_cnt=DEPTH, o_empty=1, o_full=0, o_overflow=0.
- Latency: the push edge is at cycle N; o_word_valid=1 with the first word at cycle N+1.
- Throughput: 1 word/cycle. A block drains in 4 cycles when i_word_ready is held high. Back-to-back blocks stream without bubbles.
- o_free_cnt and o_full update on the edge after the push/pop. A pop frees a slot only at the final word's transfer edge.
- i_word_ready may toggle arbitrarily. The word index advances only on transfer edges.
- The host may hold i_word_ready high while o_word_valid=0; this has no effect.

## Test plan
- Single block, ready held 1: push 69c4e0d86a7b0430d8cdb78070b4c55a with MSW_FIRST=1.
  - Required: words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a on cycles N+1..N+4.
  - o_last only on 70b4c55a; o_empty=1 at N+5.
- Same block with MSW_FIRST=0 and random ready stalls.
  - Required: words 70b4c55a, d8cdb780, 6a7b0430, 69c4e0d8.
  - o_word is stable during every stall; exactly 4 transfers.
- Fill with DEPTH=4, ready=0: push blocks A,B,C,D.
  - Required: o_full=1, o_free_cnt=0.
  - A 5th push gives o_overflow=1 and is dropped; the output order is A..D only.
- Full-boundary concurrent event: full FIFO, push E on the same edge as A's 4th-word transfer.
  - Required: E is accepted, o_overflow stays 0, o_full stays 1, and the output order is B,C,D,E.
- Enable qualification: hold i_blk_valid=1 for 3 cycles with i_enable=1,0,1.
  - Required: exactly 2 blocks are stored.
- i_clear mid-block after 2 words of A with B queued, with a simultaneous push of C.
  - Required: o_empty=1, o_free_cnt=4, o_overflow=0.
  - C is discarded; the next pushed block starts at widx 0.
  - Asynchronous reset mid-stream: same result, with o_word=0.
